// File: rtl/statelogic.sv
// statelogic: control-state sequencer for the multicycle accumulator CPU.
// Walks reset, fetch, decode and execute paths; stalls on memready; counts retires.
module statelogic #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       opcode,
  input  logic             zero,
  input  logic             memready,
  output logic [5:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic             instret,
  output logic [CNT_W-1:0] icount
);

  localparam logic [5:0] S_SPI  = 6'd0;
  localparam logic [5:0] S_F0   = 6'd1;
  localparam logic [5:0] S_F1   = 6'd2;
  localparam logic [5:0] S_F2   = 6'd3;
  localparam logic [5:0] S_F3   = 6'd4;
  localparam logic [5:0] S_DEC  = 6'd5;
  localparam logic [5:0] S_ST0  = 6'd6;
  localparam logic [5:0] S_LDI  = 6'd7;
  localparam logic [5:0] S_ALI  = 6'd8;
  localparam logic [5:0] S_REG  = 6'd9;
  localparam logic [5:0] S_MA0  = 6'd10;
  localparam logic [5:0] S_MA1  = 6'd11;
  localparam logic [5:0] S_PC0  = 6'd12;
  localparam logic [5:0] S_PC1  = 6'd13;
  localparam logic [5:0] S_PC2  = 6'd14;
  localparam logic [5:0] S_PC3  = 6'd15;
  localparam logic [5:0] S_PC4  = 6'd16;
  localparam logic [5:0] S_ASR  = 6'd17;
  localparam logic [5:0] S_LSR  = 6'd18;
  localparam logic [5:0] S_ASL  = 6'd19;
  localparam logic [5:0] S_LSL  = 6'd20;
  localparam logic [5:0] S_JMP  = 6'd21;
  localparam logic [5:0] S_JZ   = 6'd22;
  localparam logic [5:0] S_JNZ  = 6'd23;
  localparam logic [5:0] S_POP0 = 6'd24;
  localparam logic [5:0] S_PSH0 = 6'd25;
  localparam logic [5:0] S_POP1 = 6'd26;
  localparam logic [5:0] S_PSH1 = 6'd27;
  localparam logic [5:0] S_ST1  = 6'd28;
  localparam logic [5:0] S_SHW  = 6'd29;
  localparam logic [5:0] S_WB   = 6'd30;
  localparam logic [5:0] S_HLT  = 6'd31;
  localparam logic [5:0] S_INC  = 6'd32;

  localparam logic [1:0] M_IMM = 2'd0;
  localparam logic [1:0] M_REG = 2'd1;
  localparam logic [1:0] M_MEM = 2'd2;

  logic [5:0]       state_q, state_d;
  logic             halted_q, halted_d;
  logic             illegal_q, illegal_d;
  logic             instret_q, instret_d;
  logic [CNT_W-1:0] icount_q, icount_d;

  logic [7:0] grp;
  logic [1:0] mode;
  logic [1:0] sub;
  logic       unused_sub2;
  logic [5:0] dec_state;
  logic       dec_ill;
  logic       dec_halt;
  logic       is_mem;
  logic       stall;
  logic       ill_go;
  logic       retire;

  assign grp         = 8'b1 << opcode[7:5];
  assign mode        = opcode[4:3];
  assign sub         = opcode[1:0];
  assign unused_sub2 = opcode[2];

  always_comb begin
    dec_state = S_HLT;
    dec_ill   = 1'b0;
    dec_halt  = 1'b0;
    unique case (1'b1)
      grp[0]: begin
        unique case (mode)
          M_IMM:   dec_state = S_LDI;
          M_REG:   dec_state = S_REG;
          M_MEM:   dec_state = S_MA0;
          default: dec_state = S_PC0;
        endcase
      end
      grp[1]: begin
        unique case (mode)
          M_IMM:   dec_state = S_ALI;
          M_REG:   dec_state = S_REG;
          M_MEM:   dec_state = S_MA0;
          default: dec_ill   = 1'b1;
        endcase
      end
      grp[2]: dec_state = S_ST0;
      grp[3]: dec_state = S_ASR + {4'd0, sub};
      grp[4]: begin
        unique case (sub)
          2'd0:    dec_state = S_JMP;
          2'd1:    dec_state = S_JZ;
          2'd2:    dec_state = S_JNZ;
          default: dec_ill   = 1'b1;
        endcase
      end
      grp[5]: dec_state = sub[0] ? S_PSH0 : S_POP0;
      grp[6]: dec_ill  = 1'b1;
      grp[7]: dec_halt = 1'b1;
      default: dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    case (state_q)
      S_F0, S_F1, S_F2, S_F3,
      S_MA0, S_PC3, S_POP0, S_PSH0: is_mem = 1'b1;
      default:                      is_mem = 1'b0;
    endcase
  end

  assign stall = is_mem & ~memready;

  // next state; retire flags the edge that completes an instruction
  always_comb begin
    state_d = state_q;
    ill_go  = 1'b0;
    retire  = 1'b0;
    if (!stall) begin
      case (state_q)
        S_SPI:  state_d = S_F0;
        S_F0:   state_d = S_F1;
        S_F1:   state_d = S_F2;
        S_F2:   state_d = S_F3;
        S_F3:   state_d = S_DEC;
        S_DEC: begin
          state_d = dec_state;
          ill_go  = dec_ill;
          retire  = dec_halt;
        end
        S_ST0:  state_d = S_ST1;
        S_ST1:  state_d = S_INC;
        S_LDI:  state_d = S_INC;
        S_ALI:  state_d = S_WB;
        S_REG:  state_d = S_WB;
        S_MA0:  state_d = S_MA1;
        S_MA1:  state_d = S_WB;
        S_PC0:  state_d = S_PC1;
        S_PC1:  state_d = S_PC2;
        S_PC2:  state_d = S_PC3;
        S_PC3:  state_d = S_PC4;
        S_PC4:  state_d = S_WB;
        S_ASR, S_LSR,
        S_ASL, S_LSL: state_d = S_SHW;
        S_SHW:  state_d = S_INC;
        S_JMP: begin
          state_d = S_F0;
          retire  = 1'b1;
        end
        S_JZ: begin
          state_d = zero ? S_F0 : S_INC;
          retire  = zero;
        end
        S_JNZ: begin
          state_d = zero ? S_INC : S_F0;
          retire  = ~zero;
        end
        S_POP0: state_d = S_POP1;
        S_POP1: state_d = S_WB;
        S_PSH0: state_d = S_PSH1;
        S_PSH1: state_d = S_INC;
        S_WB:   state_d = S_INC;
        S_HLT:  state_d = S_HLT;
        S_INC: begin
          state_d = S_F0;
          retire  = 1'b1;
        end
        default: begin
          state_d = S_HLT;
          ill_go  = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    halted_d  = (state_d == S_HLT);
    illegal_d = illegal_q | ill_go;
    instret_d = retire;
    icount_d  = icount_q + CNT_W'(retire);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_SPI;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      instret_q <= 1'b0;
      icount_q  <= '0;
    end else begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
      icount_q  <= icount_d;
    end
  end

  assign state   = state_q;
  assign halted  = halted_q;
  assign illegal = illegal_q;
  assign instret = instret_q;
  assign icount  = icount_q;

endmodule

// File: tb/tb_statelogic.sv
// tb_statelogic: directed plan plus random opcode/memready/zero stream
// checked cycle by cycle against a path-table model of the sequencer.
module tb_statelogic;

  localparam int CW = 4;

  logic          clk;
  logic          reset_n;
  logic [7:0]    opcode;
  logic          zero;
  logic          memready;
  logic [5:0]    state;
  logic          halted;
  logic          illegal;
  logic          instret;
  logic [CW-1:0] icount;

  int n_tests;
  int n_fail;

  int            m_state;
  bit            m_halted;
  bit            m_ill;
  bit            m_inst;
  logic [CW-1:0] m_cnt;
  int            q[$];

  statelogic #(.CNT_W(CW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .opcode(opcode),
    .zero(zero),
    .memready(memready),
    .state(state),
    .halted(halted),
    .illegal(illegal),
    .instret(instret),
    .icount(icount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp,
               $time);
    end
  endtask

  task automatic cmp_all();
    chk("state", 32'(state), 32'(m_state));
    chk("halted", 32'(halted), 32'(m_halted));
    chk("illegal", 32'(illegal), 32'(m_ill));
    chk("instret", 32'(instret), 32'(m_inst));
    chk("icount", 32'(icount), 32'(m_cnt));
  endtask

  function automatic bit is_mem(int s);
    return s inside {1, 2, 3, 4, 10, 15, 24, 25};
  endfunction

  // path of states after decode, taken straight from the opcode table
  function automatic void decode(input logic [7:0] op, output bit ill,
                                 output bit hlt);
    logic [2:0] g;
    logic [1:0] m;
    logic [1:0] s;
    g = op[7:5];
    m = op[4:3];
    s = op[1:0];
    ill = 1'b0;
    hlt = 1'b0;
    q.delete();
    case (g)
      3'd0: case (m)
        2'd0: q = {7, 32};
        2'd1: q = {9, 30, 32};
        2'd2: q = {10, 11, 30, 32};
        default: q = {12, 13, 14, 15, 16, 30, 32};
      endcase
      3'd1: case (m)
        2'd0: q = {8, 30, 32};
        2'd1: q = {9, 30, 32};
        2'd2: q = {10, 11, 30, 32};
        default: ill = 1'b1;
      endcase
      3'd2: q = {6, 28, 32};
      3'd3: q = {17 + int'(s), 29, 32};
      3'd4: case (s)
        2'd0: q = {21};
        2'd1: q = {22};
        2'd2: q = {23};
        default: ill = 1'b1;
      endcase
      3'd5: if (s[0]) q = {25, 27, 32};
            else q = {24, 26, 30, 32};
      3'd6: ill = 1'b1;
      default: hlt = 1'b1;
    endcase
    if (ill || hlt) q = {31};
  endfunction

  task automatic tick(input bit mr, input bit z);
    int ns;
    bit ret;
    bit ill;
    bit hlt;
    memready = mr;
    zero = z;
    ret = 1'b0;
    ill = 1'b0;
    hlt = 1'b0;
    if (m_state == 0) ns = 1;
    else if (is_mem(m_state) && !mr) ns = m_state;
    else if (m_state == 31) ns = 31;
    else if (m_state >= 1 && m_state <= 4) ns = m_state + 1;
    else if (m_state == 5) begin
      decode(opcode, ill, hlt);
      ns = q.pop_front();
      ret = hlt;
    end else if (m_state == 22 || m_state == 23) begin
      if ((m_state == 22) ? z : !z) begin
        ns = 1;
        ret = 1'b1;
      end else ns = 32;
    end else if (q.size() != 0) ns = q.pop_front();
    else begin
      ns = 1;
      ret = 1'b1;
    end
    @(posedge clk);
    #1;
    m_state = ns;
    m_halted = (ns == 31);
    m_ill = m_ill | ill;
    m_inst = ret;
    m_cnt = m_cnt + CW'(ret);
    cmp_all();
  endtask

  task automatic model_reset();
    q.delete();
    m_state = 0;
    m_halted = 1'b0;
    m_ill = 1'b0;
    m_inst = 1'b0;
    m_cnt = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #3;
    model_reset();
    cmp_all();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // one instruction from state 0/1 until back in 1 or parked in 31
  task automatic run_instr(input logic [7:0] op, input bit rnd);
    bit seen5;
    bit done;
    seen5 = 1'b0;
    done = 1'b0;
    opcode = op;
    for (int c = 0; c < 120 && !done; c++) begin
      tick(rnd ? ($urandom_range(0, 3) != 0) : 1'b1,
           rnd ? 1'($urandom) : 1'b0);
      if (m_state == 5) seen5 = 1'b1;
      if (seen5 && (m_state == 1 || m_state == 31)) done = 1'b1;
    end
    chk("instr_done", 32'(done), 32'd1);
  endtask

  int load_seq[8] = '{1, 2, 3, 4, 5, 7, 32, 1};

  initial begin
    n_tests = 0;
    n_fail = 0;
    reset_n = 1'b0;
    opcode = 8'h00;
    zero = 1'b0;
    memready = 1'b1;
    model_reset();
    do_reset();
    chk("rst_state", 32'(state), 32'd0);

    // LOAD imm
    opcode = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b0);
      chk("load_seq", 32'(state), 32'(load_seq[i]));
    end
    chk("load_cnt", 32'(icount), 32'd1);

    // ALU mem with 3 stall cycles in state 10
    opcode = 8'h30;
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    chk("alu_s10", 32'(state), 32'd10);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0);
      chk("alu_hold", 32'(state), 32'd10);
    end
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
    chk("alu_back", 32'(state), 32'd1);
    chk("alu_cnt", 32'(icount), 32'd2);

    // JZ taken and not taken
    opcode = 8'h81;
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    chk("jz_s22", 32'(state), 32'd22);
    tick(1'b1, 1'b1);
    chk("jz_taken", 32'(state), 32'd1);
    chk("jz_ret", 32'(instret), 32'd1);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    chk("jz_fall", 32'(state), 32'd32);
    tick(1'b1, 1'b0);
    chk("jz_cnt", 32'(icount), 32'd4);

    run_instr(8'hA1, 1'b0);
    run_instr(8'hA0, 1'b0);
    chk("stk_cnt", 32'(icount), 32'd6);

    // undefined group: illegal, no retire
    run_instr(8'hC0, 1'b0);
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_halt", 32'(halted), 32'd1);
    chk("ill_cnt", 32'(icount), 32'd6);
    do_reset();

    // HALT retires once and parks
    run_instr(8'hE0, 1'b0);
    chk("hlt_cnt", 32'(icount), 32'd1);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'($urandom));
    chk("hlt_stay", 32'(state), 32'd31);
    chk("hlt_ill", 32'(illegal), 32'd0);
    do_reset();

    // async reset while stalled in state 3
    run_instr(8'h00, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk("stall_s3", 32'(state), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("async_state", 32'(state), 32'd0);
    chk("async_cnt", 32'(icount), 32'd0);
    cmp_all();
    @(negedge clk);
    reset_n = 1'b1;
    chk("rel_state", 32'(state), 32'd0);
    tick(1'b1, 1'b0);
    chk("rel_next", 32'(state), 32'd1);

    // counter wrap at 2^CW
    do_reset();
    for (int i = 0; i < 17; i++) run_instr(8'h00, 1'b1);
    chk("wrap_cnt", 32'(icount), 32'd1);

    // random stream
    for (int n = 0; n < 60; n++) begin
      logic [7:0] op;
      op = 8'($urandom);
      if (op[7:6] == 2'b11) op = 8'($urandom);
      run_instr(op, 1'b1);
      if (m_state == 31) begin
        for (int i = 0; i < 3; i++) tick(1'b1, 1'($urandom));
        do_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/statelogic.md
# statelogic

Next-state sequencer for the multicycle accumulator CPU. It holds the 6-bit control state that drives the control-signal decoder and walks it through reset, the 4-byte fetch, decode, operand fetch, execute and PC increment. It stalls memory states on a ready handshake and counts retired instructions.

## Interface
- CNT_W, 16, width of the retired-instruction counter.
- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- opcode  in  8  IR byte 0, captured by the datapath in state 1 and stable from state 2 until the next state 1.
  - [7:5] group; [4:3] addressing mode; [2:0] sub-op.
- zero  in  1  accumulator-zero flag; sampled only in states 22 and 23.
- memready  in  1  memory handshake; a memory state advances only when it is 1.
- state  out  6  current control state, 0..32; feeds the decoder.
- halted  out  1  high while state is 31.
- illegal  out  1  sticky; set when an undefined opcode is decoded; cleared only by reset.
- instret  out  1  one-cycle pulse on the cycle an instruction retires.
- icount  out  CNT_W  retired-instruction count; wraps modulo 2^CNT_W.

## Operation
- Reset values: state=0, halted=0, illegal=0, instret=0, icount=0.
- State 0 (SP init) lasts one cycle after reset release, then goes to 1.
- Fetch is 1→2→3→4→5. State 5 decodes opcode.
- Group 000, LOAD; the mode selects the path:
  - imm: 7→32.
  - reg: 9→30→32.
  - mem: 10→11→30→32.
  - pcrel: 12→13→14→15→16→30→32.
- Group 001, ALU; the mode selects the operand path:
  - imm: 8→30→32.
  - reg: 9→30→32.
  - mem: 10→11→30→32.
  - pcrel: illegal.
- Group 010, STORE: 6→28→32.
- Group 011, SHIFT; sub[1:0] selects the shift, then 29→32:
  - 00 ASR: 17.
  - 01 LSR: 18.
  - 10 ASL: 19.
  - 11 LSL: 20.
- Group 100, JUMP; sub[1:0]:
  - 00: 21→1.
  - 01: 22; next is 1 if zero=1, else 32.
  - 10: 23; next is 1 if zero=0, else 32.
  - 11: illegal.
- Group 101, STACK; sub[0]:
  - 1 PUSH: 25→27→32.
  - 0 POP: 24→26→30→32.
- Group 111, HALT: 31, held until reset.
- Group 110, and any undefined combination listed above: go to 31 and set illegal.
- Memory states are 1, 2, 3, 4, 10, 15, 24 and 25.
  - In these, state holds while memready=0 and advances on the first cycle memready=1.
  - Non-memory states ignore memready.
- Retire points:
  - 32→1.
  - 21→1.
  - 22/23→1 when the jump is taken.
  - 31, on first entry only, and only when decoded as HALT (not when entered as illegal).
  - At each retire point: instret=1 and icount+1.
- Unreachable encodings 33..63 go to 31 and set illegal.

## Timing
- Registered Moore machine. state, halted and instret update on the clk edge after the qualifying condition; next-state logic is combinational from state, opcode, zero and memready.
- instret and the icount increment occur on the edge that leaves the retiring state. For HALT they occur on the edge entering 31.
- Minimum latencies with memready=1, counted from leaving state 1 to re-entering state 1:
  - LOAD imm: 6 cycles.
  - JMP (state 21): 5 cycles.
  - POP: 8 cycles.
- Each cycle of memready=0 in a memory state adds one cycle.
- Asynchronous reset in any state, including a stalled memory state, forces all outputs to reset values immediately. Operation resumes from state 0.
- zero is sampled on the same edge that leaves 22/23. A zero change in other states has no effect.
- icount wraps from 2^CNT_W−1 to 0 without any flag.

## Test plan
- Reset, then LOAD imm (opcode 0x00), memready=1 → state sequence 0,1,2,3,4,5,7,32,1; one instret pulse; icount=1.
- ALU mem (opcode 0x30) with memready low for 3 cycles in state 10 → state holds at 10 for 3 cycles, then 11,30,32,1; icount increments once.
- JZ (opcode 0x81) with zero=1 → 5,22,1, retiring on leaving 22. With zero=0 → 5,22,32,1.
- PUSH (0xA1) → 25,27,32. POP (0xA0) → 24,26,30,32. Each retires once.
- Opcode 0xC0 → 5,31; illegal=1; halted=1; icount unchanged. HALT 0xE0 → 31, halted=1, icount+1, and state stays 31 for 10 cycles.
- Assert reset_n=0 mid-stall in state 3 → state=0 and icount=0 asynchronously. After release → 0,1.
